pulse_window_gen: RTL



---
 rtl/pulse_window_gen_pkg.sv | 16 +
 rtl/pulse_window_gen_posedge_detector.sv | 25 ++
 rtl/pulse_window_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pulse_window_gen_pkg.sv
// Shared definitions for pulse_window_gen: FSM state encoding and default widths.
package pulse_window_gen_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        DELAY  = 3'd2,
        WINDOW = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_DLY_W = 16;
    localparam int DEF_WIN_W = 16;

endpackage : pulse_window_gen_pkg

// File: rtl/pulse_window_gen_posedge_detector.sv
// Registered rising-edge detector: pulse_out is high for one cycle, one cycle after signal_in rises.
module Posedge_detector (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    output logic pulse_out
);

    logic prev_q;
    logic pulse_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= signal_in;
            pulse_q <= signal_in & ~prev_q;
        end
    end

    assign pulse_out = pulse_q;

endmodule : Posedge_detector

// File: rtl/pulse_window_gen.sv
// Per-pulse sample-window generator: delay after each trigger edge, then a data_valid_o window.
// Optional TRIG_SYNC_EN macro adds a 2-flop synchronizer on trigger_i (+2 cycles latency).
module pulse_window_gen
    import pulse_window_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DLY_W = DEF_DLY_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_i,
    input  logic             Capture_En,
    input  logic [CNT_W-1:0] Pulse_Num,
    input  logic [DLY_W-1:0] Trig_Delay,
    input  logic [WIN_W-1:0] Win_Len,
    output logic             data_valid_o,
    output logic [CNT_W-1:0] Pulse_index,
    output logic             busy,
    output logic             capture_done,
    output logic             trig_miss
);

    logic trig_src;
    logic trig_edge;
    logic cap_edge;

`ifdef TRIG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], trigger_i};
        end
    end

    assign trig_src = sync_q[1];
`else
    assign trig_src = trigger_i;
`endif

    Posedge_detector u_trig_edge (
        .clk       (clk),
        .rst       (rst),
        .signal_in (trig_src),
        .pulse_out (trig_edge)
    );

    Posedge_detector u_cap_edge (
        .clk       (clk),
        .rst       (rst),
        .signal_in (Capture_En),
        .pulse_out (cap_edge)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [DLY_W-1:0] dcnt_q, dcnt_d;
    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] pidx_q, pidx_d;
    logic             miss_q, miss_d;
    logic [CNT_W-1:0] pidx_inc;

    assign pidx_inc = pidx_q + CNT_W'(1);

    // NOTE: every variable gets its default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        dly_d   = dly_q;
        win_d   = win_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;
        pidx_d  = pidx_q;
        miss_d  = trig_edge && (state_q == DELAY || state_q == WINDOW);

        if (!Capture_En) begin
            state_d = IDLE;
            pidx_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cap_edge) begin
                        num_d   = Pulse_Num;
                        dly_d   = Trig_Delay;
                        win_d   = (Win_Len == '0) ? WIN_W'(1) : Win_Len;
                        pidx_d  = '0;
                        state_d = (Pulse_Num == '0) ? DONE : ARMED;
                    end
                end
                ARMED: begin
                    if (trig_edge) begin
                        if (dly_q == '0) begin
                            wcnt_d  = win_q;
                            state_d = WINDOW;
                        end else begin
                            dcnt_d  = dly_q;
                            state_d = DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (dcnt_q == DLY_W'(1)) begin
                        wcnt_d  = win_q;
                        state_d = WINDOW;
                    end else begin
                        dcnt_d = dcnt_q - DLY_W'(1);
                    end
                end
                WINDOW: begin
                    if (wcnt_q == WIN_W'(1)) begin
                        pidx_d  = pidx_inc;
                        state_d = (pidx_inc == num_q) ? DONE : ARMED;
                    end else begin
                        wcnt_d = wcnt_q - WIN_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            dly_q   <= '0;
            win_q   <= '0;
            dcnt_q  <= '0;
            wcnt_q  <= '0;
            pidx_q  <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            dly_q   <= dly_d;
            win_q   <= win_d;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            pidx_q  <= pidx_d;
            miss_q  <= miss_d;
        end
    end

    assign data_valid_o = (state_q == WINDOW);
    assign busy         = (state_q == ARMED) || (state_q == DELAY) || (state_q == WINDOW);
    assign capture_done = (state_q == DONE);
    assign Pulse_index  = pidx_q;
    assign trig_miss    = miss_q;

endmodule : pulse_window_gen
